watch_time_master: RTL and testbench
====================================

Name: watch_time_master

Overview:
- Avalon-MM master for the digital watch; it is the initiator side of the tick-counter slave.
- Periodically reads the free-running tick register (1 tick = 1 ms) from the timer slave and converts elapsed ticks into hh:mm:ss.
- Writes the packed BCD time to the display slave whenever the seconds value changes.
- Takes the time-keeping and display update off the Nios II CPU; software only sets the time.

Parameters:
- MADDR_WIDTH, 8, master address width.
- DATA_WIDTH, 32, data bus width.
- TIMER_ADDR, 8'h00, address of the tick register in the timer slave.
- DISP_ADDR, 8'h10, address of the display register.
- TICKS_PER_SEC, 1000, ticks per second.
- POLL_CYCLES, 50000, clk cycles between poll starts (range 2..2^20).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- avm_address  out  MADDR_WIDTH  master address.
- avm_read  out  1  read request.
- avm_write  out  1  write request.
- avm_writedata  out  DATA_WIDTH  write data.
- avm_readdata  in  DATA_WIDTH  read data.
- avm_waitrequest  in  1  slave stall.
- set_valid  in  1  one-cycle pulse requesting a time load.
- set_hh  in  5  hours to load, binary.
- set_mm  in  6  minutes to load, binary.
- set_ss  in  6  seconds to load, binary.
- set_err  out  1  one-cycle pulse when a load request is rejected.
- hh  out  5  current hours, binary.
- mm  out  6  current minutes, binary.
- ss  out  6  current seconds, binary.

Behaviour:
- Reset: clk and reset are the only clock and reset. Reset is asynchronous and active-high; it clears every register and output to 0 (avm_*, hh/mm/ss, set_err). Internally it clears the poll counter, ms_acc, last_ticks and the baseline flag, and puts the FSM in IDLE.
- Reset mid-transaction: avm_read and avm_write drop immediately; no completion is awaited.
- Poll timer: counts 0..POLL_CYCLES-1 and wraps. The wrap cycle sets poll_pend. poll_pend clears when READ is entered.
- IDLE:
  - A pending set is serviced first.
  - Otherwise, if poll_pend is set, go to READ.
- READ:
  - Drive avm_address=TIMER_ADDR and avm_read=1.
  - Hold address and read stable while avm_waitrequest=1.
  - Data is sampled in the cycle where avm_read=1 and avm_waitrequest=0. That cycle ends the read; go to CALC.
- CALC entry:
  - delta = readdata - last_ticks, modulo 2^32, so counter wrap-around is handled.
  - last_ticks <= readdata.
  - If the baseline flag is 0: set it, add nothing, go to IDLE.
  - Otherwise: ms_acc <= ms_acc + delta (32-bit; delta saturates to 2^31 before the add).
- CALC loop:
  - Each cycle that ms_acc >= TICKS_PER_SEC: subtract TICKS_PER_SEC and advance the time by one second (ss 59->0 carries to mm, mm 59->0 carries to hh, hh 23->0).
  - When ms_acc < TICKS_PER_SEC: go to WRITE if any second was advanced during this CALC, else go to IDLE.
- WRITE:
  - Drive avm_address=DISP_ADDR and avm_write=1.
  - avm_writedata = {8'h00, 2'b00, hh_bcd[5:0], 1'b0, mm_bcd[6:0], 1'b0, ss_bcd[6:0]}, i.e. bits [23:16]=hh BCD, [15:8]=mm BCD, [7:0]=ss BCD.
  - Hold while avm_waitrequest=1. Done in the cycle waitrequest=0; go to IDLE.
  - avm_read and avm_write are never asserted together.
- Time load:
  - set_valid is captured in any state into a pending register; a later pulse overwrites an unserviced one.
  - Values are validated at capture. If hh>23, mm>59 or ss>59: set_err pulses the next cycle and nothing is captured.
  - Servicing in IDLE: load hh/mm/ss, clear ms_acc, go to WRITE. This forced write happens even if the time is unchanged.
  - A load takes priority over a simultaneous poll_pend; the poll is serviced afterwards.
- A poll wrap during a busy FSM only sets poll_pend; multiple wraps collapse into one.
- hh/mm/ss outputs update in the cycle after the internal time registers change.

Test Plan:
- Reset, then two polls returning ticks 100 and 1100 with waitrequest=0 -> first poll sets the baseline only (no write); second yields ss=1; one write to DISP_ADDR with data 32'h00000001.
- Baseline 0, then a read of 3_725_000 with waitrequest held high 5 cycles -> read address/strobe stable throughout; CALC runs 3725 iterations; write data 32'h00010205 (01:02:05).
- set_hh=23, set_mm=59, set_ss=59, then a tick delta of 1000 -> displays 32'h00235959, then 32'h00000000 (midnight wrap).
- Baseline 32'hFFFF_FE0C, then a read of 32'h0000_01F4 -> delta 1000 across wrap; ss advances by exactly 1.
- set_mm=60 -> set_err pulses once; no write; time unchanged. set_valid coincident with poll_pend -> load write precedes the read.
- Assert reset while avm_write=1 and waitrequest=1 -> avm_write=0 in the same cycle; all outputs 0.

Source files
------------

// File: rtl/watch_time_master.sv
// Avalon-MM master that polls a millisecond tick counter, keeps hh:mm:ss and
// pushes the packed BCD time to the display slave whenever the seconds change.
module watch_time_master #(
  parameter int                     MADDR_WIDTH   = 8,
  parameter int                     DATA_WIDTH    = 32,
  parameter logic [MADDR_WIDTH-1:0] TIMER_ADDR    = 8'h00,
  parameter logic [MADDR_WIDTH-1:0] DISP_ADDR     = 8'h10,
  parameter int                     TICKS_PER_SEC = 1000,
  parameter int                     POLL_CYCLES   = 50000
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic [MADDR_WIDTH-1:0] avm_address,
  output logic                   avm_read,
  output logic                   avm_write,
  output logic [DATA_WIDTH-1:0]  avm_writedata,
  input  logic [DATA_WIDTH-1:0]  avm_readdata,
  input  logic                   avm_waitrequest,
  input  logic                   set_valid,
  input  logic [4:0]             set_hh,
  input  logic [5:0]             set_mm,
  input  logic [5:0]             set_ss,
  output logic                   set_err,
  output logic [4:0]             hh,
  output logic [5:0]             mm,
  output logic [5:0]             ss
);

  localparam int PCW = 20;
  localparam logic [PCW-1:0]        POLL_LAST = PCW'(POLL_CYCLES - 1);
  localparam logic [DATA_WIDTH-1:0] TPS       = DATA_WIDTH'(TICKS_PER_SEC);
  localparam logic [DATA_WIDTH-1:0] DELTA_MAX = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, READ, CALC, WRITE} state_t;

  function automatic logic [7:0] to_bcd(input logic [5:0] bin);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'(bin / 6'd10);
    ones = 4'(bin % 6'd10);
    return {tens, ones};
  endfunction

  function automatic logic [DATA_WIDTH-1:0] pack_time(input logic [4:0] h,
                                                      input logic [5:0] m,
                                                      input logic [5:0] s);
    return DATA_WIDTH'({8'h00, 2'b00, 6'(to_bcd({1'b0, h})), 1'b0,
                        7'(to_bcd(m)), 1'b0, 7'(to_bcd(s))});
  endfunction

  state_t                   state_q, state_d;
  logic [PCW-1:0]           poll_cnt_q, poll_cnt_d;
  logic                     poll_pend_q, poll_pend_d;
  logic                     set_pend_q, set_pend_d;
  logic [4:0]               set_hh_q, set_hh_d;
  logic [5:0]               set_mm_q, set_mm_d;
  logic [5:0]               set_ss_q, set_ss_d;
  logic                     set_err_q, set_err_d;
  logic                     base_q, base_d;
  logic                     adv_q, adv_d;
  logic [DATA_WIDTH-1:0]    last_ticks_q, last_ticks_d;
  logic [DATA_WIDTH-1:0]    ms_acc_q, ms_acc_d;
  logic [4:0]               t_hh_q, t_hh_d;
  logic [5:0]               t_mm_q, t_mm_d;
  logic [5:0]               t_ss_q, t_ss_d;
  logic [4:0]               hh_q, hh_d;
  logic [5:0]               mm_q, mm_d;
  logic [5:0]               ss_q, ss_d;
  logic [MADDR_WIDTH-1:0]   avm_address_q, avm_address_d;
  logic                     avm_read_q, avm_read_d;
  logic                     avm_write_q, avm_write_d;
  logic [DATA_WIDTH-1:0]    avm_writedata_q, avm_writedata_d;
  logic [DATA_WIDTH-1:0]    delta_raw;
  logic [DATA_WIDTH-1:0]    delta_sat;

  always_comb begin
    state_d         = state_q;
    poll_cnt_d      = poll_cnt_q + 20'd1;
    poll_pend_d     = poll_pend_q;
    set_pend_d      = set_pend_q;
    set_hh_d        = set_hh_q;
    set_mm_d        = set_mm_q;
    set_ss_d        = set_ss_q;
    set_err_d       = 1'b0;
    base_d          = base_q;
    adv_d           = adv_q;
    last_ticks_d    = last_ticks_q;
    ms_acc_d        = ms_acc_q;
    t_hh_d          = t_hh_q;
    t_mm_d          = t_mm_q;
    t_ss_d          = t_ss_q;
    hh_d            = t_hh_q;
    mm_d            = t_mm_q;
    ss_d            = t_ss_q;
    avm_address_d   = avm_address_q;
    avm_read_d      = avm_read_q;
    avm_write_d     = avm_write_q;
    avm_writedata_d = avm_writedata_q;
    delta_raw       = avm_readdata - last_ticks_q;
    delta_sat       = (delta_raw > DELTA_MAX) ? DELTA_MAX : delta_raw;

    if (poll_cnt_q == POLL_LAST) begin
      poll_cnt_d = {PCW{1'b0}};
    end else begin
      poll_cnt_d = poll_cnt_q + 20'd1;
    end

    case (state_q)
      IDLE: begin
        if (set_pend_q) begin
          set_pend_d      = 1'b0;
          t_hh_d          = set_hh_q;
          t_mm_d          = set_mm_q;
          t_ss_d          = set_ss_q;
          ms_acc_d        = {DATA_WIDTH{1'b0}};
          avm_address_d   = DISP_ADDR;
          avm_write_d     = 1'b1;
          avm_writedata_d = pack_time(set_hh_q, set_mm_q, set_ss_q);
          state_d         = WRITE;
        end else if (poll_pend_q) begin
          poll_pend_d   = 1'b0;
          avm_address_d = TIMER_ADDR;
          avm_read_d    = 1'b1;
          state_d       = READ;
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        if (!avm_waitrequest) begin
          avm_read_d   = 1'b0;
          last_ticks_d = avm_readdata;
          if (!base_q) begin
            base_d  = 1'b1;
            state_d = IDLE;
          end else begin
            ms_acc_d = ms_acc_q + delta_sat;
            adv_d    = 1'b0;
            state_d  = CALC;
          end
        end else begin
          state_d = READ;
        end
      end
      CALC: begin
        // One second per cycle keeps the carry chain short; large deltas just take longer.
        if (ms_acc_q >= TPS) begin
          ms_acc_d = ms_acc_q - TPS;
          adv_d    = 1'b1;
          if (t_ss_q == 6'd59) begin
            t_ss_d = 6'd0;
            if (t_mm_q == 6'd59) begin
              t_mm_d = 6'd0;
              t_hh_d = (t_hh_q == 5'd23) ? 5'd0 : t_hh_q + 5'd1;
            end else begin
              t_mm_d = t_mm_q + 6'd1;
            end
          end else begin
            t_ss_d = t_ss_q + 6'd1;
          end
        end else if (adv_q) begin
          avm_address_d   = DISP_ADDR;
          avm_write_d     = 1'b1;
          avm_writedata_d = pack_time(t_hh_q, t_mm_q, t_ss_q);
          state_d         = WRITE;
        end else begin
          state_d = IDLE;
        end
      end
      WRITE: begin
        if (!avm_waitrequest) begin
          avm_write_d = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d = WRITE;
        end
      end
      default: begin
        avm_read_d  = 1'b0;
        avm_write_d = 1'b0;
        state_d     = IDLE;
      end
    endcase

    // A wrap always re-arms the poll, even on the cycle a read is being launched.
    if (poll_cnt_q == POLL_LAST) begin
      poll_pend_d = 1'b1;
    end else begin
      poll_pend_d = poll_pend_d;
    end

    if (set_valid) begin
      if ((set_hh > 5'd23) || (set_mm > 6'd59) || (set_ss > 6'd59)) begin
        set_err_d = 1'b1;
      end else begin
        set_pend_d = 1'b1;
        set_hh_d   = set_hh;
        set_mm_d   = set_mm;
        set_ss_d   = set_ss;
      end
    end else begin
      set_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      poll_cnt_q      <= {PCW{1'b0}};
      poll_pend_q     <= 1'b0;
      set_pend_q      <= 1'b0;
      set_hh_q        <= 5'd0;
      set_mm_q        <= 6'd0;
      set_ss_q        <= 6'd0;
      set_err_q       <= 1'b0;
      base_q          <= 1'b0;
      adv_q           <= 1'b0;
      last_ticks_q    <= {DATA_WIDTH{1'b0}};
      ms_acc_q        <= {DATA_WIDTH{1'b0}};
      t_hh_q          <= 5'd0;
      t_mm_q          <= 6'd0;
      t_ss_q          <= 6'd0;
      hh_q            <= 5'd0;
      mm_q            <= 6'd0;
      ss_q            <= 6'd0;
      avm_address_q   <= {MADDR_WIDTH{1'b0}};
      avm_read_q      <= 1'b0;
      avm_write_q     <= 1'b0;
      avm_writedata_q <= {DATA_WIDTH{1'b0}};
    end else begin
      state_q         <= state_d;
      poll_cnt_q      <= poll_cnt_d;
      poll_pend_q     <= poll_pend_d;
      set_pend_q      <= set_pend_d;
      set_hh_q        <= set_hh_d;
      set_mm_q        <= set_mm_d;
      set_ss_q        <= set_ss_d;
      set_err_q       <= set_err_d;
      base_q          <= base_d;
      adv_q           <= adv_d;
      last_ticks_q    <= last_ticks_d;
      ms_acc_q        <= ms_acc_d;
      t_hh_q          <= t_hh_d;
      t_mm_q          <= t_mm_d;
      t_ss_q          <= t_ss_d;
      hh_q            <= hh_d;
      mm_q            <= mm_d;
      ss_q            <= ss_d;
      avm_address_q   <= avm_address_d;
      avm_read_q      <= avm_read_d;
      avm_write_q     <= avm_write_d;
      avm_writedata_q <= avm_writedata_d;
    end
  end

  assign avm_address   = avm_address_q;
  assign avm_read      = avm_read_q;
  assign avm_write     = avm_write_q;
  assign avm_writedata = avm_writedata_q;
  assign set_err       = set_err_q;
  assign hh            = hh_q;
  assign mm            = mm_q;
  assign ss            = ss_q;

endmodule

// File: tb/tb_watch_time_master.sv
// Directed bench for watch_time_master with a small Avalon slave model.
module tb_watch_time_master;

  localparam int POLL = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;
  logic        set_valid = 1'b0;
  logic [4:0]  set_hh = 5'd0;
  logic [5:0]  set_mm = 6'd0;
  logic [5:0]  set_ss = 6'd0;
  logic        set_err;
  logic [4:0]  hh;
  logic [5:0]  mm;
  logic [5:0]  ss;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] rd_value = 32'd0;
  int          hold_n = 0;
  int          busy_cnt = 0;
  int          rd_done = 0;
  int          wr_done = 0;
  logic [7:0]  last_wr_addr = 8'h00;
  logic [31:0] last_wr_data = 32'd0;
  int          ev_log[$];
  bit          both_seen = 1'b0;

  watch_time_master #(
    .MADDR_WIDTH(8), .DATA_WIDTH(32), .TIMER_ADDR(8'h00), .DISP_ADDR(8'h10),
    .TICKS_PER_SEC(1000), .POLL_CYCLES(POLL)
  ) dut (
    .clk(clk), .reset(reset),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest),
    .set_valid(set_valid), .set_hh(set_hh), .set_mm(set_mm), .set_ss(set_ss),
    .set_err(set_err), .hh(hh), .mm(mm), .ss(ss)
  );

  always #5 clk = ~clk;

  assign avm_readdata    = rd_value;
  assign avm_waitrequest = (avm_read || avm_write) && (busy_cnt < hold_n);

  // Slave model: stalls each transfer for hold_n cycles and logs completed transfers.
  always @(posedge clk) begin
    if (reset) busy_cnt <= 0;
    else if ((avm_read || avm_write) && avm_waitrequest) busy_cnt <= busy_cnt + 1;
    else busy_cnt <= 0;
    if (!reset && avm_read && !avm_waitrequest) begin
      rd_done <= rd_done + 1;
      ev_log.push_back(1);
    end
    if (!reset && avm_write && !avm_waitrequest) begin
      wr_done      <= wr_done + 1;
      last_wr_addr <= avm_address;
      last_wr_data <= avm_writedata;
      ev_log.push_back(2);
    end
    if (avm_read && avm_write) both_seen <= 1'b1;
  end

  task automatic apply_reset();
    reset = 1'b1; set_valid = 1'b0; hold_n = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_reads(input int n, input int budget);
    int tgt;
    tgt = rd_done + n;
    for (int i = 0; i < budget && rd_done < tgt; i++) @(negedge clk);
  endtask

  task automatic wait_writes(input int n, input int budget);
    int tgt;
    tgt = wr_done + n;
    for (int i = 0; i < budget && wr_done < tgt; i++) @(negedge clk);
  endtask

  task automatic set_time(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
    set_hh = h; set_mm = m; set_ss = s; set_valid = 1'b1;
    @(negedge clk);
    set_valid = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({avm_read, avm_write, set_err} !== 3'b000) begin
      errors++; $display("FAIL reset_strobes got %b want 000", {avm_read, avm_write, set_err});
    end
    checks++;
    if ({hh, mm, ss} !== 17'd0 || avm_address !== 8'h00 || avm_writedata !== 32'd0) begin
      errors++; $display("FAIL reset_values got %0d:%0d:%0d addr %h data %h want zeros", hh, mm, ss, avm_address, avm_writedata);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic_poll();
    int w0;
    apply_reset();
    w0 = wr_done;
    rd_value = 32'd100;
    wait_reads(1, 400);
    repeat (10) @(negedge clk);
    checks++;
    if (wr_done !== w0) begin
      errors++; $display("FAIL baseline_no_write got %0d writes want 0", wr_done - w0);
    end
    rd_value = 32'd1100;
    wait_reads(1, 400);
    wait_writes(1, 100);
    checks++;
    if (wr_done !== w0 + 1) begin
      errors++; $display("FAIL basic_write_count got %0d want 1", wr_done - w0);
    end
    checks++;
    if (last_wr_addr !== 8'h10 || last_wr_data !== 32'h0000_0001) begin
      errors++; $display("FAIL basic_write got addr %h data %h want 10 00000001", last_wr_addr, last_wr_data);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (hh !== 5'd0 || mm !== 6'd0 || ss !== 6'd1) begin
      errors++; $display("FAIL basic_time got %0d:%0d:%0d want 0:0:1", hh, mm, ss);
    end
  endtask

  task automatic test_waitrequest();
    int r0, rd_hi, wait_hi, bad;
    apply_reset();
    rd_value = 32'd0;
    wait_reads(1, 400);
    hold_n = 5;
    rd_value = 32'd3_725_000;
    r0 = rd_done; rd_hi = 0; wait_hi = 0; bad = 0;
    for (int i = 0; i < 400 && rd_done == r0; i++) begin
      @(negedge clk);
      if (avm_read) begin
        rd_hi++;
        if (avm_waitrequest) wait_hi++;
        if (avm_address !== 8'h00 || avm_write) bad++;
      end
    end
    checks++;
    if (rd_hi != 6 || wait_hi != 5 || bad != 0) begin
      errors++; $display("FAIL read_stall got read_cycles %0d stall_cycles %0d unstable %0d want 6 5 0", rd_hi, wait_hi, bad);
    end
    wait_writes(1, 5000);
    checks++;
    if (last_wr_addr !== 8'h10 || last_wr_data !== 32'h0001_0205) begin
      errors++; $display("FAIL big_delta_write got addr %h data %h want 10 00010205", last_wr_addr, last_wr_data);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (hh !== 5'd1 || mm !== 6'd2 || ss !== 6'd5) begin
      errors++; $display("FAIL big_delta_time got %0d:%0d:%0d want 1:2:5", hh, mm, ss);
    end
    hold_n = 0;
  endtask

  task automatic test_midnight();
    int w0;
    apply_reset();
    rd_value = 32'd5000;
    wait_reads(1, 400);
    w0 = wr_done;
    set_time(5'd23, 6'd59, 6'd59);
    wait_writes(1, 100);
    checks++;
    if (wr_done !== w0 + 1 || last_wr_data !== 32'h0023_5959) begin
      errors++; $display("FAIL load_write got %0d writes data %h want 1 00235959", wr_done - w0, last_wr_data);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (hh !== 5'd23 || mm !== 6'd59 || ss !== 6'd59) begin
      errors++; $display("FAIL load_time got %0d:%0d:%0d want 23:59:59", hh, mm, ss);
    end
    rd_value = 32'd6000;
    wait_writes(1, 400);
    checks++;
    if (wr_done !== w0 + 2 || last_wr_data !== 32'h0000_0000) begin
      errors++; $display("FAIL midnight_write got %0d writes data %h want 2 00000000", wr_done - w0, last_wr_data);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (hh !== 5'd0 || mm !== 6'd0 || ss !== 6'd0) begin
      errors++; $display("FAIL midnight_time got %0d:%0d:%0d want 0:0:0", hh, mm, ss);
    end
  endtask

  task automatic test_counter_wrap();
    int w0;
    apply_reset();
    rd_value = 32'hFFFF_FE0C;
    wait_reads(1, 400);
    w0 = wr_done;
    rd_value = 32'h0000_01F4;
    wait_writes(1, 400);
    checks++;
    if (wr_done !== w0 + 1 || last_wr_data !== 32'h0000_0001) begin
      errors++; $display("FAIL wrap_write got %0d writes data %h want 1 00000001", wr_done - w0, last_wr_data);
    end
    wait_reads(1, 400);
    repeat (10) @(negedge clk);
    checks++;
    if (wr_done !== w0 + 1 || ss !== 6'd1 || mm !== 6'd0) begin
      errors++; $display("FAIL wrap_single_sec got %0d writes ss %0d mm %0d want 1 1 0", wr_done - w0, ss, mm);
    end
  endtask

  task automatic test_set_err();
    int w1;
    apply_reset();
    rd_value = 32'd0;
    wait_reads(1, 400);
    set_time(5'd10, 6'd20, 6'd30);
    wait_writes(1, 100);
    checks++;
    if (last_wr_data !== 32'h0010_2030) begin
      errors++; $display("FAIL valid_load got %h want 00102030", last_wr_data);
    end
    w1 = wr_done;
    set_time(5'd10, 6'd60, 6'd0);
    checks++;
    if (set_err !== 1'b1) begin
      errors++; $display("FAIL set_err_pulse got %b want 1", set_err);
    end
    @(negedge clk);
    checks++;
    if (set_err !== 1'b0) begin
      errors++; $display("FAIL set_err_single got %b want 0", set_err);
    end
    repeat (2 * POLL) @(negedge clk);
    checks++;
    if (wr_done !== w1 || hh !== 5'd10 || mm !== 6'd20 || ss !== 6'd30) begin
      errors++; $display("FAIL rejected_load got %0d writes time %0d:%0d:%0d want 0 10:20:30", wr_done - w1, hh, mm, ss);
    end
  endtask

  task automatic test_priority();
    int idx;
    for (int i = 0; i < 200 && !avm_read; i++) @(negedge clk);
    checks++;
    if (avm_read !== 1'b1) begin
      errors++; $display("FAIL poll_seen got %b want 1", avm_read);
    end
    repeat (POLL - 2) @(negedge clk);
    idx = ev_log.size();
    set_time(5'd5, 6'd6, 6'd7);
    wait_writes(1, 100);
    wait_reads(1, 200);
    checks++;
    if (ev_log.size() < idx + 2) begin
      errors++; $display("FAIL priority_events got %0d want 2", ev_log.size() - idx);
    end else if (ev_log[idx] != 2 || ev_log[idx+1] != 1) begin
      errors++; $display("FAIL priority_order got %0d,%0d want 2,1 (write then read)", ev_log[idx], ev_log[idx+1]);
    end
    checks++;
    if (last_wr_data !== 32'h0005_0607) begin
      errors++; $display("FAIL priority_data got %h want 00050607", last_wr_data);
    end
  endtask

  task automatic test_reset_mid_write();
    apply_reset();
    rd_value = 32'd0;
    wait_reads(1, 400);
    hold_n = 1000;
    set_time(5'd1, 6'd2, 6'd3);
    for (int i = 0; i < 50 && !avm_write; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    checks++;
    if (avm_write !== 1'b1 || hh !== 5'd1) begin
      errors++; $display("FAIL stalled_write got write %b hh %0d want 1 1", avm_write, hh);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (avm_write !== 1'b0 || avm_read !== 1'b0) begin
      errors++; $display("FAIL async_drop got write %b read %b want 0 0", avm_write, avm_read);
    end
    checks++;
    if ({hh, mm, ss} !== 17'd0 || avm_address !== 8'h00 || avm_writedata !== 32'd0 || set_err !== 1'b0) begin
      errors++; $display("FAIL async_clear got %0d:%0d:%0d addr %h data %h err %b want zeros", hh, mm, ss, avm_address, avm_writedata, set_err);
    end
    hold_n = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_exclusive();
    checks++;
    if (both_seen !== 1'b0) begin
      errors++; $display("FAIL read_write_exclusive got %b want 0", both_seen);
    end
  endtask

  initial begin
    test_reset();
    test_basic_poll();
    test_waitrequest();
    test_midnight();
    test_counter_wrap();
    test_set_err();
    test_priority();
    test_reset_mid_write();
    test_exclusive();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
